// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
//   Provides the FSM state encoding, the next-PC select codes, the redirect
//   payload struct, and helpers that rank redirect sources by priority.
package pc_seq_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        WAIT_REDIR = 2'd2,
        HALTED     = 2'd3
    } seqState_e;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_JMP = 3'd1,
        SEL_BR  = 3'd2,
        SEL_EXC = 3'd3,
        SEL_RST = 3'd4
    } selCode_e;

    typedef struct packed {
        selCode_e        sel;
        logic [PC_W-1:0] target;
    } redirect_t;

    // Priority rank of a redirect source; higher wins.
    function automatic logic [1:0] selRank(input selCode_e s);
        case (s)
            SEL_EXC: return 2'd3;
            SEL_BR:  return 2'd2;
            SEL_JMP: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Branches and exceptions flush both pipeline registers and beat stalls.
    function automatic logic isHighRedir(input selCode_e s);
        return (s == SEL_BR) || (s == SEL_EXC);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational priority select for the next PC.
//   Order: exception > branch > jump (unless masked) > curPC + 4.
// Ports:
//   curPC        in   current PC
//   jumpEn       in   jump resolved in ID
//   jumpTarget   in   jump address
//   jumpMask     in   suppress the jump (hazard stall in progress)
//   branchTaken  in   taken branch resolved in EX
//   branchTarget in   branch address
//   excReq       in   exception request
//   choice       out  winning select code and target
module pc_next_mux
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic [PC_W-1:0] curPC,
    input  logic            jumpEn,
    input  logic [PC_W-1:0] jumpTarget,
    input  logic            jumpMask,
    input  logic            branchTaken,
    input  logic [PC_W-1:0] branchTarget,
    input  logic            excReq,
    output redirect_t       choice
);

    // Sequential target wraps naturally modulo 2^32.
    always_comb begin
        choice.sel    = SEL_SEQ;
        choice.target = curPC + PC_INC;
        if (excReq) begin
            choice.sel    = SEL_EXC;
            choice.target = EXC_VECTOR;
        end else if (branchTaken) begin
            choice.sel    = SEL_BR;
            choice.target = branchTarget;
        end else if (jumpEn && !jumpMask) begin
            choice.sel    = SEL_JMP;
            choice.target = jumpTarget;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the 32-bit PC register of the pipelined core.
//   Arbitrates sequential fetch, jumps, branches, exceptions, hazard stalls
//   and halt; handshakes with instruction memory and issues pipeline flushes.
//   PC write data/enable, fetch request and flushes respond combinationally
//   to the same-cycle imem_ack so the PC register updates on the ack edge.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   curPC                 PC register output
//   nextPC, pcWrite       PC register write data / enable
//   imem_req, imem_ack    fetch handshake
//   hazard_stall          load-use stall
//   jump_en/jump_target   ID jump
//   branch_taken/_target  EX branch
//   exc_req               exception request
//   halt                  halt decoded in ID
//   flush_ifid/flush_idex pipeline register clears
//   seq_state             FSM state for debug
//   stall_cnt/redirect_cnt  perf counters (only with PC_SEQ_PERF_EN)
// Configuration macro: PC_SEQ_PERF_EN adds saturating perf counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [PC_W-1:0] EXC_VECTOR   = 32'h0000_0080
`ifdef PC_SEQ_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] curPC,
    output logic [PC_W-1:0] nextPC,
    output logic            pcWrite,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic            hazard_stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            exc_req,
    input  logic            halt,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic [1:0]      seq_state
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
`endif
);

    seqState_e state;
    seqState_e stateNext;
    redirect_t pendReg;
    redirect_t pendNext;
    redirect_t choice;

    assign seq_state = state;

    // A jump under a hazard stall is masked so it re-presents after the stall.
    pc_next_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_mux (
        .curPC        (curPC),
        .jumpEn       (jump_en),
        .jumpTarget   (jump_target),
        .jumpMask     (hazard_stall),
        .branchTaken  (branch_taken),
        .branchTarget (branch_target),
        .excReq       (exc_req),
        .choice       (choice)
    );

    // State and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            pendReg <= '0;
        end else begin
            state   <= stateNext;
            pendReg <= pendNext;
        end
    end

    // Next-state and output logic.
    always_comb begin
        stateNext  = state;
        pendNext   = pendReg;
        nextPC     = curPC;
        pcWrite    = 1'b0;
        imem_req   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        unique case (state)
            BOOT: begin
                pcWrite   = 1'b1;
                nextPC    = RESET_VECTOR;
                stateNext = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (isHighRedir(choice.sel)) begin
                        pcWrite    = 1'b1;
                        nextPC     = choice.target;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (!hazard_stall) begin
                        // Halt outranks a jump: both come from ID and halt stops fetch.
                        if (halt) begin
                            stateNext = HALTED;
                        end else begin
                            pcWrite    = 1'b1;
                            nextPC     = choice.target;
                            flush_ifid = (choice.sel == SEL_JMP);
                        end
                    end
                end else if (choice.sel != SEL_SEQ) begin
                    pendNext  = choice;
                    stateNext = WAIT_REDIR;
                end
            end

            WAIT_REDIR: begin
                imem_req = 1'b1;
                // Same-cycle arrivals merge before the ack write.
                if ((choice.sel != SEL_SEQ) &&
                    (selRank(choice.sel) >= selRank(pendReg.sel))) begin
                    pendNext = choice;
                end
                if (imem_ack) begin
                    pcWrite    = 1'b1;
                    nextPC     = pendNext.target;
                    flush_ifid = 1'b1;
                    flush_idex = isHighRedir(pendNext.sel);
                    pendNext   = '0;
                    stateNext  = FETCH;
                end
            end

            HALTED: stateNext = HALTED;

            default: stateNext = BOOT;
        endcase

        if (reset) begin
            nextPC     = RESET_VECTOR;
            pcWrite    = 1'b0;
            imem_req   = 1'b0;
            flush_ifid = 1'b0;
            flush_idex = 1'b0;
        end
    end

`ifdef PC_SEQ_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating perf counters; every redirect write also flushes IF/ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if ((hazard_stall || (imem_req && !imem_ack)) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_ifid && (redirect_cnt != CNT_MAX)) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed steps followed by random traffic, all
// checked against a behavioural model of the next-PC rules. The bench also
// plays the role of the PC register (curPC follows the model's writes).
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;
    localparam int unsigned CW = 16;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] curPC = 32'h0;
    logic [31:0] nextPC;
    logic        pcWrite;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic        hazard_stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        exc_req = 1'b0;
    logic        halt = 1'b0;
    logic        flush_ifid;
    logic        flush_idex;
    logic [1:0]  seq_state;
`ifdef PC_SEQ_PERF_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] redirect_cnt;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .curPC         (curPC),
        .nextPC        (nextPC),
        .pcWrite       (pcWrite),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .hazard_stall  (hazard_stall),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exc_req       (exc_req),
        .halt          (halt),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .seq_state     (seq_state)
`ifdef PC_SEQ_PERF_EN
        ,
        .stall_cnt     (stall_cnt),
        .redirect_cnt  (redirect_cnt)
`endif
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Model state: booting / halted / pending redirect (rank 3 exc, 2 br, 1 jmp).
    bit          mBoot = 1'b1, mHalted = 1'b0, mPend = 1'b0;
    int          mRank = 0;
    logic [31:0] mTgt = 32'h0;
    int unsigned mStall = 0, mRedir = 0;
    bit          nBoot, nHalted, nPend;
    int          nRank;
    logic [31:0] nTgt;
    int unsigned nStall, nRedir;

    // Expected outputs for the current cycle.
    logic        eWrite, eReq, eIfid, eIdex, chkNext;
    logic [31:0] eNext;
    logic [1:0]  eState;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        int cr;
        logic [31:0] ct;
        eWrite = 1'b0; eReq = 1'b0; eIfid = 1'b0; eIdex = 1'b0;
        eNext = RV; chkNext = 1'b0;
        eState = mBoot ? 2'd0 : (mHalted ? 2'd3 : (mPend ? 2'd2 : 2'd1));
        nBoot = mBoot; nHalted = mHalted; nPend = mPend; nRank = mRank; nTgt = mTgt;
        cr = 0; ct = 32'h0;
        if (reset) begin
            chkNext = 1'b1;
            nBoot = 1'b1; nHalted = 1'b0; nPend = 1'b0; nRank = 0;
        end else if (mBoot) begin
            eWrite = 1'b1; eNext = RV; nBoot = 1'b0;
        end else if (!mHalted) begin
            eReq = 1'b1;
            if (exc_req) begin cr = 3; ct = EV; end
            else if (branch_taken) begin cr = 2; ct = branch_target; end
            else if (jump_en && !hazard_stall) begin cr = 1; ct = jump_target; end
            if (mPend) begin
                if (cr != 0 && cr >= nRank) begin nRank = cr; nTgt = ct; end
                if (imem_ack) begin
                    eWrite = 1'b1; eNext = nTgt; eIfid = 1'b1; eIdex = (nRank >= 2);
                    nPend = 1'b0;
                end
            end else if (imem_ack) begin
                if (cr >= 2) begin
                    eWrite = 1'b1; eNext = ct; eIfid = 1'b1; eIdex = 1'b1;
                end else if (!hazard_stall) begin
                    if (halt) nHalted = 1'b1;
                    else if (cr == 1) begin eWrite = 1'b1; eNext = ct; eIfid = 1'b1; end
                    else begin eWrite = 1'b1; eNext = curPC + 32'd4; end
                end
            end else if (cr != 0) begin
                nPend = 1'b1; nRank = cr; nTgt = ct;
            end
        end
        if (eWrite) chkNext = 1'b1;
        if (reset) begin
            nStall = 0; nRedir = 0;
        end else begin
            nStall = mStall;
            nRedir = mRedir;
            if ((hazard_stall || (eReq && !imem_ack)) && nStall < CMAX) nStall++;
            if (eWrite && eIfid && nRedir < CMAX) nRedir++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        predict();
        chk("pcWrite", 32'(pcWrite), 32'(eWrite));
        chk("imem_req", 32'(imem_req), 32'(eReq));
        chk("flush_ifid", 32'(flush_ifid), 32'(eIfid));
        chk("flush_idex", 32'(flush_idex), 32'(eIdex));
        chk("seq_state", 32'(seq_state), 32'(eState));
        if (chkNext) chk("nextPC", nextPC, eNext);
`ifdef PC_SEQ_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), mStall);
        chk("redirect_cnt", 32'(redirect_cnt), mRedir);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (eWrite) curPC = eNext;
        mBoot = nBoot; mHalted = nHalted; mPend = nPend; mRank = nRank; mTgt = nTgt;
        mStall = nStall; mRedir = nRedir;
    endtask

    task automatic setIn(input bit rst, input bit ack, input bit stl, input bit jmp,
                         input logic [31:0] jt, input bit br, input logic [31:0] bt,
                         input bit exc, input bit hlt);
        reset = rst; imem_ack = ack; hazard_stall = stl;
        jump_en = jmp; jump_target = jt;
        branch_taken = br; branch_target = bt;
        exc_req = exc; halt = hlt;
    endtask

    initial begin
        bit          r;
        logic [31:0] t1;
        logic [31:0] t2;

        @(posedge clk);
        #1;

        // Reset state.
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("rst_nextPC", nextPC, 32'h0); tick();

        // 1: boot then sequential fetch.
        setIn(0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("t1_boot", nextPC, 32'h0); chk("t1_boot_we", 32'(pcWrite), 32'd1); tick();
        settle(); chk("t1_pc4", nextPC, 32'h4); tick();
        settle(); chk("t1_pc8", nextPC, 32'h8); chk("t1_noflush", 32'(flush_ifid), 32'd0); tick();

        // 2: jump at PC=8.
        setIn(0, 1, 0, 1, 32'h40, 0, 0, 0, 0);
        settle(); chk("t2_jump", nextPC, 32'h40); chk("t2_ifid", 32'(flush_ifid), 32'd1);
        chk("t2_idex", 32'(flush_idex), 32'd0); tick();

        // 3: branch overrides stall; no PC advance during remaining stall.
        setIn(0, 1, 1, 0, 0, 1, 32'h100, 0, 0);
        settle(); chk("t3_branch", nextPC, 32'h100); chk("t3_idex", 32'(flush_idex), 32'd1); tick();
        setIn(0, 1, 1, 1, 32'h500, 0, 0, 0, 0);
        settle(); chk("t3_stall_we", 32'(pcWrite), 32'd0); tick();

        // 4: redirects while ack low; exception overrides pending branch.
        setIn(0, 0, 0, 0, 0, 1, 32'h200, 0, 0);
        settle(); chk("t4_noack_we", 32'(pcWrite), 32'd0); tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle(); chk("t4_wait", 32'(seq_state), 32'd2); tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        setIn(0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("t4_exc", nextPC, 32'h80); chk("t4_idex", 32'(flush_idex), 32'd1); tick();

        // 5: halt loses to branch; halt alone parks until reset.
        setIn(0, 1, 0, 0, 0, 1, 32'h300, 0, 1);
        settle(); chk("t5_branch", nextPC, 32'h300); tick();
        setIn(0, 1, 0, 0, 0, 0, 0, 0, 1);
        settle(); chk("t5_halt_we", 32'(pcWrite), 32'd0); tick();
        setIn(0, 1, 0, 1, 32'h40, 0, 0, 0, 0);
        settle(); chk("t5_halted", 32'(seq_state), 32'd3); chk("t5_noreq", 32'(imem_req), 32'd0); tick();
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        setIn(0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("t5_boot", 32'(seq_state), 32'd0); tick();

        // 6: sequential wrap at the top of the address space.
        setIn(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        settle(); tick();
        setIn(0, 1, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("t6_wrap", nextPC, 32'h0); tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(99) == 0) || (mHalted && $urandom_range(9) == 0);
            t1 = $urandom & 32'hFFFF_FFFC;
            t2 = $urandom & 32'hFFFF_FFFC;
            setIn(r, $urandom_range(3) != 0, $urandom_range(4) == 0,
                  $urandom_range(6) == 0, t1, $urandom_range(9) == 0, t2,
                  $urandom_range(19) == 0, $urandom_range(49) == 0);
            settle();
            tick();
        end

`ifdef PC_SEQ_PERF_EN
        // Counter saturation: every cycle is both a stall and a redirect.
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        for (int i = 0; i < int'(CMAX) + 8; i++) begin
            t2 = $urandom & 32'hFFFF_FFFC;
            setIn(0, 1, 1, 0, 0, 1, t2, 0, 0);
            settle();
            tick();
        end
        settle();
        chk("stall_sat", 32'(stall_cnt), CMAX);
        chk("redirect_sat", 32'(redirect_cnt), CMAX);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
